apb2iob_wide: RTL and testbench



---
 rtl/apb2iob_wide.sv | 146 ++++++++++++++
 tb/tb_apb2iob_wide.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb2iob_wide.sv
// APB slave to IOb master bridge: each APB transfer becomes RATIO sequential narrow IOb beats.
// Define APB2IOB_WIDE_TIMEOUT_EN to build the per-beat timeout with APB error response.
module apb2iob_wide #(
   parameter int APB_ADDR_W = 21,
   parameter int APB_DATA_W = 32,
   parameter int ADDR_W     = APB_ADDR_W,
   parameter int DATA_W     = 8,
   parameter int RATIO      = APB_DATA_W / DATA_W,
   parameter int TIMEOUT    = 255
) (
   input  logic                    clk_i,
   input  logic                    cke_i,
   input  logic                    rst_n_i,
   input  logic                    apb_sel_i,
   input  logic                    apb_enable_i,
   input  logic                    apb_write_i,
   input  logic [APB_ADDR_W-1:0]   apb_addr_i,
   input  logic [APB_DATA_W-1:0]   apb_wdata_i,
   input  logic [APB_DATA_W/8-1:0] apb_wstrb_i,
   output logic [APB_DATA_W-1:0]   apb_rdata_o,
   output logic                    apb_ready_o,
   output logic                    apb_slverr_o,
   output logic                    iob_avalid_o,
   output logic [ADDR_W-1:0]       iob_addr_o,
   output logic [DATA_W-1:0]       iob_wdata_o,
   output logic [DATA_W/8-1:0]     iob_wstrb_o,
   input  logic                    iob_rvalid_i,
   input  logic [DATA_W-1:0]       iob_rdata_i,
   input  logic                    iob_ready_i
);

   localparam int APB_STRB_W = APB_DATA_W / 8;
   localparam int STRB_W     = DATA_W / 8;
   localparam int BEAT_W     = (RATIO > 1) ? $clog2(RATIO) : 1;
   localparam logic [APB_ADDR_W-1:0] ADDR_MASK  = ~(APB_ADDR_W'(APB_STRB_W - 1));
   localparam logic [APB_ADDR_W-1:0] BEAT_BYTES = APB_ADDR_W'(STRB_W);
   localparam logic [BEAT_W-1:0]     LAST_BEAT  = BEAT_W'(RATIO - 1);

   typedef enum logic [1:0] {IDLE, REQ, WAIT_R, RESP} state_t;

   state_t                  state_q, state_d;
   logic [BEAT_W-1:0]       beat_q, beat_d;
   logic [APB_DATA_W-1:0]   rdata_q;
   logic [APB_ADDR_W-1:0]   beat_addr;
   logic [DATA_W-1:0]       beat_wdata;
   logic [STRB_W-1:0]       beat_strb;
   logic                    start, skip, beat_done, rd_store, tmo_fire;

   always_comb begin
      beat_addr  = (apb_addr_i & ADDR_MASK) + APB_ADDR_W'(beat_q) * BEAT_BYTES;
      beat_wdata = apb_wdata_i[beat_q*DATA_W +: DATA_W];
      beat_strb  = apb_wstrb_i[beat_q*STRB_W +: STRB_W];
   end

   assign start        = (state_q == IDLE) && apb_sel_i;
   assign skip         = (state_q == REQ) && apb_write_i && (beat_strb == '0);
   assign iob_avalid_o = (state_q == REQ) && !skip;
   assign iob_addr_o   = ADDR_W'(beat_addr);
   assign iob_wdata_o  = beat_wdata;
   assign iob_wstrb_o  = apb_write_i ? beat_strb : '0;
   assign apb_ready_o  = (state_q == RESP) && apb_enable_i;
   assign apb_rdata_o  = rdata_q;

   // Beat completion is resolved separately so the timeout can depend on it without a false loop
   always_comb begin
      beat_done = 1'b0;
      rd_store  = 1'b0;
      case (state_q)
         REQ:     beat_done = skip || (iob_ready_i && apb_write_i);
         WAIT_R: begin
            rd_store  = iob_rvalid_i;
            beat_done = iob_rvalid_i;
         end
         default: ;
      endcase
   end

   always_comb begin
      state_d = state_q;
      beat_d  = beat_q;
      case (state_q)
         IDLE: if (apb_sel_i) begin
            state_d = REQ;
            beat_d  = '0;
         end
         REQ:     if (iob_ready_i && !apb_write_i) state_d = WAIT_R;
         WAIT_R:  ;
         RESP:    if (apb_enable_i) state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (beat_done) begin
         if (beat_q == LAST_BEAT) begin
            state_d = RESP;
         end else begin
            state_d = REQ;
            beat_d  = beat_q + 1'b1;
         end
      end
      if (tmo_fire) state_d = RESP;
   end

   always_ff @(posedge clk_i) begin
      if (cke_i) begin
         if (!rst_n_i) begin
            state_q <= IDLE;
            beat_q  <= '0;
            rdata_q <= '0;
         end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            if (start || tmo_fire) rdata_q <= '0;
            else if (rd_store)     rdata_q[beat_q*DATA_W +: DATA_W] <= iob_rdata_i;
         end
      end
   end

`ifdef APB2IOB_WIDE_TIMEOUT_EN
   logic [15:0] tmo_q;
   logic        err_q;
   logic        tmo_clr;

   // Counter restarts on every entry to REQ, i.e. the limit applies per beat
   assign tmo_clr  = start || (beat_done && (beat_q != LAST_BEAT));
   assign tmo_fire = ((state_q == REQ) || (state_q == WAIT_R)) && !beat_done &&
                     (tmo_q == 16'(TIMEOUT - 1));
   assign apb_slverr_o = apb_ready_o && err_q;

   always_ff @(posedge clk_i) begin
      if (cke_i) begin
         if (!rst_n_i) begin
            tmo_q <= '0;
            err_q <= 1'b0;
         end else begin
            if (tmo_clr) tmo_q <= '0;
            else if ((state_q == REQ) || (state_q == WAIT_R)) tmo_q <= tmo_q + 1'b1;
            if (start)         err_q <= 1'b0;
            else if (tmo_fire) err_q <= 1'b1;
         end
      end
   end
`else
   assign tmo_fire     = 1'b0;
   assign apb_slverr_o = 1'b0;
`endif

endmodule

// File: tb/tb_apb2iob_wide.sv
// Directed bench for apb2iob_wide: a 32/8 instance driven by a latency-configurable IOb model,
// and a 32/32 instance driven cycle by cycle.
module tb_apb2iob_wide;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   // 32-bit APB over 8-bit IOb
   logic        a_sel, a_en, a_wr;
   logic [20:0] a_addr;
   logic [31:0] a_wdata, a_rdata;
   logic [3:0]  a_wstrb;
   logic        a_ready, a_slverr, a_avalid, a_iready, a_rvalid;
   logic [20:0] a_iaddr;
   logic [7:0]  a_iwdata, a_irdata;
   logic [0:0]  a_iwstrb;

   // 32-bit APB over 32-bit IOb
   logic        b_sel, b_en, b_wr;
   logic [20:0] b_addr;
   logic [31:0] b_wdata, b_rdata, b_iwdata, b_irdata;
   logic [3:0]  b_wstrb, b_iwstrb;
   logic        b_ready, b_slverr, b_avalid, b_iready, b_rvalid;
   logic [20:0] b_iaddr;

   apb2iob_wide #(.APB_ADDR_W(21), .APB_DATA_W(32), .DATA_W(8), .TIMEOUT(10)) u_dut_a (
      .clk_i(clk), .cke_i(1'b1), .rst_n_i(rst_n),
      .apb_sel_i(a_sel), .apb_enable_i(a_en), .apb_write_i(a_wr), .apb_addr_i(a_addr),
      .apb_wdata_i(a_wdata), .apb_wstrb_i(a_wstrb), .apb_rdata_o(a_rdata),
      .apb_ready_o(a_ready), .apb_slverr_o(a_slverr),
      .iob_avalid_o(a_avalid), .iob_addr_o(a_iaddr), .iob_wdata_o(a_iwdata),
      .iob_wstrb_o(a_iwstrb), .iob_rvalid_i(a_rvalid), .iob_rdata_i(a_irdata),
      .iob_ready_i(a_iready)
   );

   apb2iob_wide #(.APB_ADDR_W(21), .APB_DATA_W(32), .DATA_W(32), .TIMEOUT(10)) u_dut_b (
      .clk_i(clk), .cke_i(1'b1), .rst_n_i(rst_n),
      .apb_sel_i(b_sel), .apb_enable_i(b_en), .apb_write_i(b_wr), .apb_addr_i(b_addr),
      .apb_wdata_i(b_wdata), .apb_wstrb_i(b_wstrb), .apb_rdata_o(b_rdata),
      .apb_ready_o(b_ready), .apb_slverr_o(b_slverr),
      .iob_avalid_o(b_avalid), .iob_addr_o(b_iaddr), .iob_wdata_o(b_iwdata),
      .iob_wstrb_o(b_iwstrb), .iob_rvalid_i(b_rvalid), .iob_rdata_i(b_irdata),
      .iob_ready_i(b_iready)
   );

   int unsigned n_chk = 0;
   int unsigned n_err = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // IOb slave model for instance A: ready after ready_lat waiting cycles, rvalid rv_lat cycles after accept
   int unsigned ready_lat = 0, rv_lat = 1, a_wait = 0, rv_cnt = 0;
   logic        ready_en = 1'b1;
   logic [1:0]  rd_idx = '0;
   logic [7:0]  resp [4];
   int unsigned log_n = 0, n_pulse = 0, n_avalid = 0;
   logic [20:0] log_addr  [64];
   logic [7:0]  log_wdata [64];
   logic        log_wstrb [64];

   assign a_iready = a_avalid && ready_en && (a_wait >= ready_lat);
   assign a_rvalid = (rv_cnt == 1);
   assign a_irdata = resp[rd_idx];

   always @(posedge clk) begin
      if (!rst_n) begin
         a_wait <= 0;
         rv_cnt <= 0;
      end else begin
         if (a_avalid && !a_iready) a_wait <= a_wait + 1;
         else                       a_wait <= 0;
         if (a_avalid && a_iready && !a_wr) begin
            rv_cnt <= rv_lat;
            rd_idx <= a_iaddr[1:0];
         end else if (rv_cnt != 0) begin
            rv_cnt <= rv_cnt - 1;
         end
      end
      if (a_avalid && a_iready) begin
         log_addr[log_n % 64]  <= a_iaddr;
         log_wdata[log_n % 64] <= a_iwdata;
         log_wstrb[log_n % 64] <= a_iwstrb[0];
         log_n <= log_n + 1;
      end
      if (a_ready)  n_pulse  <= n_pulse + 1;
      if (a_avalid) n_avalid <= n_avalid + 1;
   end

   // Called at a negedge; returns at the negedge after the ready cycle with sel dropped
   task automatic apb_xfer(input logic wr, input logic [20:0] addr, input logic [31:0] wdata,
                           input logic [3:0] wstrb, output int unsigned lat,
                           output logic [31:0] rd, output logic err);
      int unsigned p0;
      p0 = n_pulse;
      lat = 0;
      a_sel = 1'b1; a_en = 1'b0; a_wr = wr; a_addr = addr; a_wdata = wdata; a_wstrb = wstrb;
      do begin
         @(negedge clk);
         a_en = 1'b1;
         #1;
         lat++;
      end while (!a_ready && lat < 200);
      rd  = a_rdata;
      err = a_slverr;
      @(negedge clk);
      a_sel = 1'b0; a_en = 1'b0;
      #1;
      check("ready_single_pulse", 64'(n_pulse - p0), 64'd1);
      check("ready_low_after", 64'(a_ready), 64'd0);
   endtask

   task automatic check_beat(input string tag, input int unsigned idx, input logic [20:0] addr,
                             input logic [7:0] data, input logic strb);
      check({tag, "_addr"}, 64'(log_addr[idx % 64]), 64'(addr));
      if (strb) check({tag, "_wdata"}, 64'(log_wdata[idx % 64]), 64'(data));
      check({tag, "_wstrb"}, 64'(log_wstrb[idx % 64]), 64'(strb));
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned lat, s, av0;
      logic [31:0] rd;
      logic        err;

      rst_n = 1'b0;
      a_sel = 0; a_en = 0; a_wr = 0; a_addr = '0; a_wdata = '0; a_wstrb = '0;
      b_sel = 0; b_en = 0; b_wr = 0; b_addr = '0; b_wdata = '0; b_wstrb = '0;
      b_iready = 0; b_rvalid = 0; b_irdata = '0;
      resp[0] = 8'h00; resp[1] = 8'h00; resp[2] = 8'h00; resp[3] = 8'h00;
      repeat (3) @(negedge clk);
      check("rst_avalid", 64'(a_avalid), 64'd0);
      check("rst_ready", 64'(a_ready), 64'd0);
      check("rst_slverr", 64'(a_slverr), 64'd0);
      check("rst_rdata", 64'(a_rdata), 64'd0);
      check("rst_b_avalid", 64'(b_avalid), 64'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // full-strobe write, zero-wait IOb
      s = log_n;
      apb_xfer(1'b1, 21'h103, 32'hAABBCCDD, 4'hF, lat, rd, err);
      check("wr_full_latency", 64'(lat), 64'd5);
      check("wr_full_nbeats", 64'(log_n - s), 64'd4);
      check_beat("wr_full_b0", s + 0, 21'h100, 8'hDD, 1'b1);
      check_beat("wr_full_b1", s + 1, 21'h101, 8'hCC, 1'b1);
      check_beat("wr_full_b2", s + 2, 21'h102, 8'hBB, 1'b1);
      check_beat("wr_full_b3", s + 3, 21'h103, 8'hAA, 1'b1);
      check("wr_full_slverr", 64'(err), 64'd0);

      // sparse strobes: only beats 0 and 2 reach the IOb side
      s = log_n;
      apb_xfer(1'b1, 21'h101, 32'hAABBCCDD, 4'h5, lat, rd, err);
      check("wr_sparse_latency", 64'(lat), 64'd5);
      check("wr_sparse_nbeats", 64'(log_n - s), 64'd2);
      check_beat("wr_sparse_b0", s + 0, 21'h100, 8'hDD, 1'b1);
      check_beat("wr_sparse_b1", s + 1, 21'h102, 8'hBB, 1'b1);

      // no strobes at all
      s = log_n;
      apb_xfer(1'b1, 21'h100, 32'h12345678, 4'h0, lat, rd, err);
      check("wr_nostrb_nbeats", 64'(log_n - s), 64'd0);
      check("wr_nostrb_slverr", 64'(err), 64'd0);

      // zero-wait read
      resp[0] = 8'h01; resp[1] = 8'h02; resp[2] = 8'h03; resp[3] = 8'h04;
      ready_lat = 0; rv_lat = 1;
      s = log_n;
      apb_xfer(1'b0, 21'h206, 32'h0, 4'h0, lat, rd, err);
      check("rd_zw_latency", 64'(lat), 64'd9);
      check("rd_zw_rdata", 64'(rd), 64'h04030201);
      check_beat("rd_zw_b0", s + 0, 21'h204, 8'h00, 1'b0);
      check_beat("rd_zw_b3", s + 3, 21'h207, 8'h00, 1'b0);

      // read with rvalid two cycles after each ready
      resp[0] = 8'h11; resp[1] = 8'h22; resp[2] = 8'h33; resp[3] = 8'h44;
      rv_lat = 2;
      apb_xfer(1'b0, 21'h200, 32'h0, 4'h0, lat, rd, err);
      check("rd_slow_latency", 64'(lat), 64'd13);
      check("rd_slow_rdata", 64'(rd), 64'h44332211);
      check("rd_slow_slverr", 64'(err), 64'd0);
      repeat (3) @(negedge clk);
      check("rd_hold_idle", 64'(a_rdata), 64'h44332211);
      apb_xfer(1'b1, 21'h200, 32'h0, 4'h0, lat, rd, err);
      check("rdata_zero_after_wr", 64'(a_rdata), 64'd0);

`ifdef APB2IOB_WIDE_TIMEOUT_EN
      // IOb never accepts: the bridge must give up after TIMEOUT cycles
      ready_en = 1'b0;
      av0 = n_avalid;
      apb_xfer(1'b0, 21'h400, 32'h0, 4'h0, lat, rd, err);
      check("tmo_avalid_cycles", 64'(n_avalid - av0), 64'd10);
      check("tmo_latency", 64'(lat), 64'd11);
      check("tmo_slverr", 64'(err), 64'd1);
      check("tmo_rdata", 64'(rd), 64'd0);
      ready_en = 1'b1;
`endif

      // reset in WAIT_R of beat 2, then a fresh read
      rv_lat = 3;
      s = log_n;
      a_sel = 1'b1; a_en = 1'b0; a_wr = 1'b0; a_addr = 21'h300;
      lat = 0;
      do begin
         @(negedge clk);
         a_en = 1'b1;
         lat++;
      end while (log_n - s < 3 && lat < 100);
      check("rst_mid_reached_b2", 64'(log_n - s), 64'd3);
      rst_n = 1'b0; a_sel = 1'b0; a_en = 1'b0;
      @(negedge clk);
      check("rst_mid_avalid", 64'(a_avalid), 64'd0);
      check("rst_mid_ready", 64'(a_ready), 64'd0);
      check("rst_mid_rdata", 64'(a_rdata), 64'd0);
      rst_n = 1'b1;
      @(negedge clk);
      resp[0] = 8'h5A; resp[1] = 8'hA5; resp[2] = 8'h3C; resp[3] = 8'hC3;
      rv_lat = 1;
      apb_xfer(1'b0, 21'h300, 32'h0, 4'h0, lat, rd, err);
      check("rst_fresh_latency", 64'(lat), 64'd9);
      check("rst_fresh_rdata", 64'(rd), 64'hC33CA55A);

      // single-beat instance: read with ready and rvalid each one cycle late
      b_sel = 1'b1; b_wr = 1'b0; b_addr = 21'h043; b_en = 1'b0;
      @(negedge clk);
      b_en = 1'b1;
      #1;
      check("b_rd_avalid_c1", 64'(b_avalid), 64'd1);
      check("b_rd_addr", 64'(b_iaddr), 64'h040);
      check("b_rd_wstrb", 64'(b_iwstrb), 64'd0);
      @(negedge clk);
      b_iready = 1'b1;
      #1;
      check("b_rd_avalid_c2", 64'(b_avalid), 64'd1);
      @(negedge clk);
      b_iready = 1'b0;
      #1;
      check("b_rd_wait_avalid", 64'(b_avalid), 64'd0);
      @(negedge clk);
      b_rvalid = 1'b1; b_irdata = 32'hCAFEF00D;
      #1;
      check("b_rd_ready_early", 64'(b_ready), 64'd0);
      @(negedge clk);
      b_rvalid = 1'b0;
      #1;
      check("b_rd_ready", 64'(b_ready), 64'd1);
      check("b_rd_rdata", 64'(b_rdata), 64'hCAFEF00D);
      check("b_rd_slverr", 64'(b_slverr), 64'd0);
      @(negedge clk);
      b_sel = 1'b0; b_en = 1'b0;
      #1;
      check("b_rd_ready_done", 64'(b_ready), 64'd0);

      // single-beat write passes the whole word and strobes through
      b_sel = 1'b1; b_wr = 1'b1; b_addr = 21'h010; b_wdata = 32'h12345678; b_wstrb = 4'h3;
      b_iready = 1'b1;
      @(negedge clk);
      b_en = 1'b1;
      #1;
      check("b_wr_wdata", 64'(b_iwdata), 64'h12345678);
      check("b_wr_wstrb", 64'(b_iwstrb), 64'h3);
      @(negedge clk);
      b_iready = 1'b0;
      #1;
      check("b_wr_ready", 64'(b_ready), 64'd1);
      @(negedge clk);
      b_sel = 1'b0; b_en = 1'b0;

      repeat (2) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
      $finish;
   end

endmodule
